// File: rtl/obi_sram_mgr_shim_pkg.sv
// Shared OBI configuration and channel types for the SRAM-to-OBI manager shim.
// Mirrors the subset of the OBI package that the shim and its users rely on.
package obi_sram_mgr_shim_pkg;

  // Manager/subordinate port configuration.
  typedef struct packed {
    logic        UseRReady;
    logic        CombGnt;
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    logic        Integrity;
  } obi_cfg_t;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 1;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b1,
    CombGnt:   1'b0,
    AddrWidth: ObiAddrWidth,
    DataWidth: ObiDataWidth,
    IdWidth:   ObiIdWidth,
    Integrity: 1'b0
  };

  // Optional address-phase attributes; the shim always drives them to zero.
  typedef struct packed {
    logic [5:0] atop;
    logic [1:0] memtype;
    logic [2:0] prot;
  } obi_a_optional_t;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
    obi_a_optional_t           a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        req;
    logic        rready;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/obi_sram_mgr_shim_fifo.sv
// Small response FIFO with optional fall-through: when empty, a pushed
// element is visible on data_o in the same cycle and may be popped at once.
module obi_sram_mgr_shim_fifo #(
  parameter bit          FALL_THROUGH = 1'b1,
  parameter int unsigned DEPTH        = 2,
  parameter type         dtype        = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  input  dtype                       data_i,
  input  logic                       push_i,
  output dtype                       data_o,
  input  logic                       pop_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  dtype            mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            is_empty, bypass, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign is_empty = (cnt_q == '0);
  assign full_o   = (cnt_q == CntW'(DEPTH));
  assign empty_o  = is_empty & ~(FALL_THROUGH & push_i);
  assign usage_o  = cnt_q;

  // An element pushed and popped in the same cycle into an empty FIFO never
  // touches storage.
  assign bypass   = FALL_THROUGH & is_empty & push_i & pop_i;
  assign do_push  = push_i & ~full_o & ~bypass;
  assign do_pop   = pop_i & ~empty_o & ~bypass;
  assign data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_ptr_q];

  // Pointer and fill-level bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage write.
  // NOTE: the data array is deliberately not reset; the fill level alone
  // decides what is valid, so resetting it would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/obi_sram_mgr_shim.sv
// SRAM-style requester (req/gnt, rvalid/rready) to OBI manager port bridge.
// A credit counter bounds transactions that are granted on OBI but not yet
// consumed by the requester; responses wait in a fall-through FIFO so the
// requester may stall while the OBI side keeps rready high.
module obi_sram_mgr_shim #(
  parameter obi_sram_mgr_shim_pkg::obi_cfg_t ObiCfg =
    obi_sram_mgr_shim_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_sram_mgr_shim_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_sram_mgr_shim_pkg::obi_rsp_t,
  parameter int unsigned MaxTrans = 2,
  parameter logic [ObiCfg.IdWidth-1:0] Aid = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [ObiCfg.AddrWidth-1:0]   addr_i,
  input  logic [ObiCfg.DataWidth-1:0]   wdata_i,
  input  logic [ObiCfg.DataWidth/8-1:0] be_i,
  output logic                          gnt_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [ObiCfg.DataWidth-1:0]   rdata_o,
  output logic                          err_o,
  output obi_req_t                      obi_req_o,
  input  obi_rsp_t                      obi_rsp_i
);

  import obi_sram_mgr_shim_pkg::*;

  localparam int unsigned DataWidth = ObiCfg.DataWidth;
  localparam int unsigned CntW      = cnt_width(MaxTrans);
  localparam int unsigned FifoDepth = (MaxTrans < 1) ? 1 : MaxTrans;

  // Configurations the shim cannot honour are rejected at elaboration.
  if (MaxTrans == 0) begin : gen_bad_max_trans
    $error("obi_sram_mgr_shim: MaxTrans must be at least 1");
  end
  if (ObiCfg.Integrity) begin : gen_bad_integrity
    $error("obi_sram_mgr_shim: integrity signals are not supported");
  end

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } rsp_entry_t;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] fifo_usage;
  logic            credit_ok, req_allowed, bus_hs, rsp_pop;
  logic            fifo_full, fifo_empty;
  rsp_entry_t      fifo_in, fifo_out;

  // Credits depend only on registered state, so rready_i never reaches the
  // OBI request combinationally.
  assign credit_ok   = (cnt_q < CntW'(MaxTrans));
  assign req_allowed = req_i & credit_ok;
  assign bus_hs      = req_allowed & obi_rsp_i.gnt;
  assign gnt_o       = bus_hs;
  assign rsp_pop     = rvalid_o & rready_i;

  // OBI address phase: pass-through payload, fixed ID, optional fields zero.
  // NOTE: assigning the whole struct a default first keeps every field
  // driven on every path, so no latch can be inferred.
  always_comb begin
    obi_req_o          = '0;
    obi_req_o.req      = req_allowed;
    obi_req_o.rready   = 1'b1;
    obi_req_o.a.addr   = addr_i;
    obi_req_o.a.we     = we_i;
    obi_req_o.a.be     = be_i;
    obi_req_o.a.wdata  = wdata_i;
    obi_req_o.a.aid    = Aid;
  end

  // Credit counter next value: grant adds, requester pop releases.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({bus_hs, rsp_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Credit counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // A response carrying a foreign ID is surfaced as an error, not dropped.
  assign fifo_in.rdata = obi_rsp_i.r.rdata;
  assign fifo_in.err   = obi_rsp_i.r.err | (obi_rsp_i.r.rid != Aid);

  obi_sram_mgr_shim_fifo #(
    .FALL_THROUGH (1'b1),
    .DEPTH        (FifoDepth),
    .dtype        (rsp_entry_t)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (fifo_in),
    .push_i  (obi_rsp_i.rvalid),
    .data_o  (fifo_out),
    .pop_i   (rsp_pop)
  );

  // Response data is held at zero whenever nothing is being presented.
  assign rvalid_o = ~fifo_empty;
  assign rdata_o  = rvalid_o ? fifo_out.rdata : '0;
  assign err_o    = rvalid_o & fifo_out.err;

  // Credits must keep the FIFO from ever overflowing.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(obi_rsp_i.rvalid && fifo_full))
    else $error("obi_sram_mgr_shim: response pushed into full FIFO");

  // A response may only arrive for a transaction still outstanding on the bus.
  a_rsp_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    obi_rsp_i.rvalid |-> (cnt_q != fifo_usage))
    else $error("obi_sram_mgr_shim: response with nothing outstanding on bus");

endmodule

// File: tb/tb_obi_sram_mgr_shim.sv
// Self-checking bench: directed scenarios followed by a randomized phase
// checked against a transaction-level model (in-order response queues plus a
// word memory behind the responder).
module tb_obi_sram_mgr_shim;
  import obi_sram_mgr_shim_pkg::*;

  localparam int unsigned MaxTrans = 2;
  localparam logic [ObiIdWidth-1:0] Aid = '0;
  localparam int unsigned RndCycles = 3000;

  logic        clk_i, rst_ni;
  logic        req_i, we_i, rready_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  obi_req_t    obi_req;
  obi_rsp_t    obi_rsp;

  int unsigned n_checks, n_fail;

  obi_sram_mgr_shim #(
    .ObiCfg   (ObiDefaultConfig),
    .obi_req_t(obi_req_t),
    .obi_rsp_t(obi_rsp_t),
    .MaxTrans (MaxTrans),
    .Aid      (Aid)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .be_i     (be_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .obi_req_o(obi_req),
    .obi_rsp_i(obi_rsp)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rsp_drive(input logic [31:0] d, input logic e, input logic [ObiIdWidth-1:0] id);
    obi_rsp.rvalid  = 1'b1;
    obi_rsp.r.rdata = d;
    obi_rsp.r.err   = e;
    obi_rsp.r.rid   = id;
  endtask

  task automatic rsp_idle();
    obi_rsp.rvalid = 1'b0;
    obi_rsp.r      = '0;
  endtask

  task automatic idle_inputs();
    req_i    = 1'b0;
    we_i     = 1'b0;
    addr_i   = '0;
    wdata_i  = '0;
    be_i     = '0;
    rready_i = 1'b0;
    obi_rsp  = '0;
  endtask

  // Model types for the randomized phase.
  typedef struct {
    logic [31:0]           rdata;
    logic                  err;
    logic [ObiIdWidth-1:0] rid;
    int                    due;
  } bus_rsp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  bus_rsp_t    bus_q[$];
  exp_rsp_t    held_q[$];
  logic [31:0] mem_model [16];

  initial begin
    int       hs;
    logic     exp_gnt, exp_rvalid, req_done;
    exp_rsp_t head;
    bus_rsp_t nb;
    int       w;

    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst_ni = 1'b0;

    // ---------------- reset / idle ----------------
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_obi_req", obi_req.req, 1'b0);
    check("rst_gnt", gnt_o, 1'b0);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_cnt", dut.cnt_q, 2'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    check("idle_obi_req", obi_req.req, 1'b0);
    check("idle_gnt", gnt_o, 1'b0);
    check("idle_rvalid", rvalid_o, 1'b0);
    check("idle_cnt", dut.cnt_q, 2'd0);

    // ---------------- single read, immediate grant ----------------
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; be_i = 4'hF; obi_rsp.gnt = 1'b1;
    #1;
    check("sr_obi_req", obi_req.req, 1'b1);
    check("sr_gnt", gnt_o, 1'b1);
    check("sr_addr", obi_req.a.addr, 32'h10);
    check("sr_we", obi_req.a.we, 1'b0);
    check("sr_aid", obi_req.a.aid, Aid);
    check("sr_optional", obi_req.a.a_optional, '0);
    check("sr_rready", obi_req.rready, 1'b1);
    @(negedge clk_i);
    req_i = 1'b0; obi_rsp.gnt = 1'b0; rready_i = 1'b1;
    rsp_drive(32'hDEADBEEF, 1'b0, Aid);
    #1;
    check("sr_rvalid", rvalid_o, 1'b1);
    check("sr_rdata", rdata_o, 32'hDEADBEEF);
    check("sr_err", err_o, 1'b0);
    check("sr_cnt_busy", dut.cnt_q, 2'd1);
    @(negedge clk_i);
    rsp_idle(); rready_i = 1'b0;
    #1;
    check("sr_cnt_done", dut.cnt_q, 2'd0);
    check("sr_rvalid_done", rvalid_o, 1'b0);

    // ---------------- three writes, credit limit ----------------
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; wdata_i = 32'h11; obi_rsp.gnt = 1'b1;
    #1;
    check("wr0_gnt", gnt_o, 1'b1);
    check("wr0_we", obi_req.a.we, 1'b1);
    check("wr0_wdata", obi_req.a.wdata, 32'h11);
    @(negedge clk_i);
    addr_i = 32'h4; wdata_i = 32'h22;
    rsp_drive(32'h1000, 1'b0, Aid);
    #1;
    check("wr1_gnt", gnt_o, 1'b1);
    @(negedge clk_i);
    addr_i = 32'h8; wdata_i = 32'h33;
    rsp_drive(32'h1001, 1'b0, Aid);
    #1;
    check("wr2_obi_req_blocked", obi_req.req, 1'b0);
    check("wr2_gnt_blocked", gnt_o, 1'b0);
    check("wr2_cnt_full", dut.cnt_q, 2'd2);
    @(negedge clk_i);
    rsp_idle();
    #1;
    check("wr2_gnt_still_blocked", gnt_o, 1'b0);
    check("wr_rvalid_held", rvalid_o, 1'b1);
    check("wr_rdata_head0", rdata_o, 32'h1000);
    @(negedge clk_i);
    rready_i = 1'b1;
    #1;
    check("wr2_gnt_pop_cycle", gnt_o, 1'b0);
    check("wr_pop0_rdata", rdata_o, 32'h1000);
    @(negedge clk_i);
    rready_i = 1'b0;
    #1;
    check("wr2_gnt_after_pop", gnt_o, 1'b1);
    check("wr2_addr", obi_req.a.addr, 32'h8);
    @(negedge clk_i);
    req_i = 1'b0; obi_rsp.gnt = 1'b0; rready_i = 1'b1;
    rsp_drive(32'h1002, 1'b0, Aid);
    #1;
    check("wr_pop1_rdata", rdata_o, 32'h1001);
    @(negedge clk_i);
    rsp_idle();
    #1;
    check("wr_pop2_rvalid", rvalid_o, 1'b1);
    check("wr_pop2_rdata", rdata_o, 32'h1002);
    @(negedge clk_i);
    rready_i = 1'b0;
    #1;
    check("wr_cnt_drained", dut.cnt_q, 2'd0);
    check("wr_rvalid_drained", rvalid_o, 1'b0);

    // ---------------- delayed grant ----------------
    hs = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; obi_rsp.gnt = 1'b0;
      #1;
      check("gl_gnt_low", gnt_o, 1'b0);
      check("gl_obi_req", obi_req.req, 1'b1);
      check("gl_addr_stable", obi_req.a.addr, 32'h100);
      hs += int'(obi_req.req & obi_rsp.gnt);
    end
    @(negedge clk_i);
    obi_rsp.gnt = 1'b1;
    #1;
    check("gl_gnt_high", gnt_o, 1'b1);
    check("gl_addr_at_gnt", obi_req.a.addr, 32'h100);
    hs += int'(obi_req.req & obi_rsp.gnt);
    @(negedge clk_i);
    req_i = 1'b0; obi_rsp.gnt = 1'b0; rready_i = 1'b1;
    rsp_drive(32'h55AA55AA, 1'b1, Aid);
    #1;
    hs += int'(obi_req.req & obi_rsp.gnt);
    check("err_rvalid", rvalid_o, 1'b1);
    check("err_flag", err_o, 1'b1);
    check("err_rdata", rdata_o, 32'h55AA55AA);
    @(negedge clk_i);
    rsp_idle(); rready_i = 1'b0;
    #1;
    check("gl_handshakes", hs, 1);
    check("gl_cnt", dut.cnt_q, 2'd0);

    // ---------------- response ID mismatch ----------------
    @(negedge clk_i);
    req_i = 1'b1; addr_i = 32'h200; obi_rsp.gnt = 1'b1;
    #1;
    check("rid_gnt", gnt_o, 1'b1);
    @(negedge clk_i);
    req_i = 1'b0; obi_rsp.gnt = 1'b0; rready_i = 1'b1;
    rsp_drive(32'hCAFEF00D, 1'b0, ~Aid);
    #1;
    check("rid_err", err_o, 1'b1);
    check("rid_rdata", rdata_o, 32'hCAFEF00D);
    @(negedge clk_i);
    rsp_idle(); rready_i = 1'b0;

    // ---------------- grant and pop together, then reset ----------------
    @(negedge clk_i);
    req_i = 1'b1; addr_i = 32'h300; obi_rsp.gnt = 1'b1;
    #1;
    check("sc_a_gnt", gnt_o, 1'b1);
    @(negedge clk_i);
    req_i = 1'b0; obi_rsp.gnt = 1'b0;
    rsp_drive(32'h0000000A, 1'b0, Aid);
    #1;
    check("sc_a_rvalid", rvalid_o, 1'b1);
    @(negedge clk_i);
    req_i = 1'b1; addr_i = 32'h304; obi_rsp.gnt = 1'b1; rready_i = 1'b1;
    rsp_idle();
    #1;
    check("sc_b_gnt", gnt_o, 1'b1);
    check("sc_pop_rdata", rdata_o, 32'h0000000A);
    @(negedge clk_i);
    addr_i = 32'h308; rready_i = 1'b0;
    rsp_drive(32'h0000000B, 1'b0, Aid);
    #1;
    check("sc_cnt_unchanged", dut.cnt_q, 2'd1);
    check("sc_c_gnt", gnt_o, 1'b1);
    @(negedge clk_i);
    req_i = 1'b0; obi_rsp.gnt = 1'b0;
    rsp_idle();
    #1;
    check("sc_cnt_two", dut.cnt_q, 2'd2);
    check("sc_rvalid_before_rst", rvalid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_cnt", dut.cnt_q, 2'd0);
    check("mid_rst_rvalid", rvalid_o, 1'b0);
    @(negedge clk_i);
    #1;
    check("mid_rst_cnt_next", dut.cnt_q, 2'd0);
    check("mid_rst_rvalid_next", rvalid_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ---------------- randomized traffic vs. model ----------------
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    idle_inputs();
    req_done = 1'b0;
    for (int cyc = 0; cyc < int'(RndCycles); cyc++) begin
      @(negedge clk_i);
      if (req_done) begin
        req_i    = 1'b0;
        req_done = 1'b0;
      end
      if (!req_i && $urandom_range(0, 3) != 0) begin
        req_i   = 1'b1;
        we_i    = 1'($urandom);
        addr_i  = {26'h0, 4'($urandom), 2'b00};
        wdata_i = $urandom;
        be_i    = 4'($urandom);
      end
      obi_rsp.gnt = ($urandom_range(0, 9) < 7);
      rready_i    = ($urandom_range(0, 9) < 6);
      if (bus_q.size() > 0 && bus_q[0].due <= cyc)
        rsp_drive(bus_q[0].rdata, bus_q[0].err, bus_q[0].rid);
      else
        rsp_idle();
      #1;

      exp_gnt    = req_i & obi_rsp.gnt & ((bus_q.size() + held_q.size()) < MaxTrans);
      exp_rvalid = (held_q.size() > 0) || obi_rsp.rvalid;
      check("rnd_gnt", gnt_o, exp_gnt);
      check("rnd_rvalid", rvalid_o, exp_rvalid);
      if (req_i) check("rnd_addr", obi_req.a.addr, addr_i);
      if (exp_rvalid) begin
        if (held_q.size() > 0) head = held_q[0];
        else begin
          head.rdata = bus_q[0].rdata;
          head.err   = bus_q[0].err | (bus_q[0].rid != Aid);
        end
        check("rnd_rdata", rdata_o, head.rdata);
        check("rnd_err", err_o, head.err);
      end

      // Advance the model to the state after the coming clock edge.
      if (obi_rsp.rvalid) begin
        nb = bus_q.pop_front();
        held_q.push_back('{rdata: nb.rdata, err: nb.err | (nb.rid != Aid)});
      end
      if (exp_rvalid && rready_i) void'(held_q.pop_front());
      if (exp_gnt) begin
        w = int'(addr_i[5:2]);
        if (we_i) begin
          for (int b = 0; b < 4; b++)
            if (be_i[b]) mem_model[w][8*b +: 8] = wdata_i[8*b +: 8];
          nb.rdata = $urandom;
        end else begin
          nb.rdata = mem_model[w];
        end
        nb.err = ($urandom_range(0, 15) == 0);
        nb.rid = ($urandom_range(0, 15) == 0) ? ~Aid : Aid;
        nb.due = cyc + int'($urandom_range(1, 3));
        bus_q.push_back(nb);
        req_done = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
